// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared types and constants for the two-port Ram arbiter.
// Revision : 1.0
// ============================================================================
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pick
// Purpose  : Winner select between two requesters; round-robin by default,
//            fixed port-0 priority when RAM_ARBITER_FIXED_PRIO_EN is defined.
// Revision : 1.0
// ============================================================================
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_accept,
    output logic o_win
);

`ifdef RAM_ARBITER_FIXED_PRIO_EN
    logic w_unused;
    assign w_unused = clk ^ rst_n ^ i_accept;
    assign o_win    = i_req0 ? PORT0 : PORT1;
`else
    // Port served most recently; reset value makes port 0 win the first tie.
    logic r_last;

    always_comb begin
        o_win = PORT0;
        if (i_req0 && i_req1) begin
            o_win = ~r_last;
        end else if (i_req1) begin
            o_win = PORT1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PORT1;
        end else if (i_accept) begin
            r_last <= o_win;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Shares one strobed 8-bit Ram between Filter (port 0) and host
//            (port 1). Option macro: RAM_ARBITER_FIXED_PRIO_EN.
// Revision : 1.0
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Write0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] WData0,
    output logic              Ack0,
    output logic [DATA_W-1:0] RData0,
    input  logic              Req1,
    input  logic              Write1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData1,
    output logic              Ack1,
    output logic [DATA_W-1:0] RData1,
    output logic              Busy,
    output logic [ADDR_W-1:0] MemAddr,
    inout  wire  [DATA_W-1:0] MemData,
    output logic              MemClk,
    output logic              MemWrite
);

    localparam int CNT_MAX = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] c_setup_last  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_strobe_last = CNT_W'(STROBE_CYCLES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_win;
    logic              r_drive;
    logic [DATA_W-1:0] r_wdata;
    logic              w_win;
    logic              w_accept;

    assign w_accept = (r_state == IDLE) && (Req0 || Req1);

    ram_arb_pick u_pick (
        .clk      (Clock),
        .rst_n    (Reset),
        .i_req0   (Req0),
        .i_req1   (Req1),
        .i_accept (w_accept),
        .o_win    (w_win)
    );

    // The bus is only ever driven between SETUP entry and HOLD exit of a write.
    assign MemData = r_drive ? r_wdata : {DATA_W{1'bz}};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_win    <= PORT0;
            r_drive  <= 1'b0;
            r_wdata  <= '0;
            MemClk   <= 1'b0;
            MemWrite <= 1'b0;
            MemAddr  <= '0;
            Ack0     <= 1'b0;
            Ack1     <= 1'b0;
            RData0   <= '0;
            RData1   <= '0;
            Busy     <= 1'b0;
        end else begin
            Ack0 <= 1'b0;
            Ack1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= SETUP;
                        r_cnt   <= '0;
                        r_win   <= w_win;
                        Busy    <= 1'b1;
                        if (w_win == PORT1) begin
                            MemAddr  <= Addr1;
                            MemWrite <= Write1;
                            r_drive  <= Write1;
                            r_wdata  <= WData1;
                        end else begin
                            MemAddr  <= Addr0;
                            MemWrite <= Write0;
                            r_drive  <= Write0;
                            r_wdata  <= WData0;
                        end
                    end
                end
                SETUP: begin
                    if (r_cnt == c_setup_last) begin
                        r_state <= STROBE;
                        r_cnt   <= '0;
                        MemClk  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STROBE: begin
                    if (r_cnt == c_strobe_last) begin
                        r_state <= HOLD;
                        MemClk  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    r_state  <= DONE;
                    MemWrite <= 1'b0;
                    r_drive  <= 1'b0;
                    if (r_win == PORT1) begin
                        Ack1 <= 1'b1;
                        if (!MemWrite) RData1 <= MemData;
                    end else begin
                        Ack0 <= 1'b1;
                        if (!MemWrite) RData0 <= MemData;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    Busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter: transaction-level model plus
//            directed scenarios, including a SETUP=3/STROBE=2 instance.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int S = 1;
    localparam int B = 1;
    localparam int T = S + B + 2;   // busy cycles per access: SETUP..DONE

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Req0 = 1'b0, Write0 = 1'b0, Req1 = 1'b0, Write1 = 1'b0;
    logic [15:0] Addr0 = '0, Addr1 = '0;
    logic [7:0]  WData0 = '0, WData1 = '0;
    logic        Ack0, Ack1, Busy, MemClk, MemWrite;
    logic [7:0]  RData0, RData1;
    logic [15:0] MemAddr;
    wire  [7:0]  MemData;

    logic        Req0_2 = 1'b0, Write0_2 = 1'b0, Req1_2 = 1'b0, Write1_2 = 1'b0;
    logic [15:0] Addr0_2 = '0, Addr1_2 = '0;
    logic [7:0]  WData0_2 = '0, WData1_2 = '0;
    logic        Ack0_2, Ack1_2, Busy_2, MemClk_2, MemWrite_2;
    logic [7:0]  RData0_2, RData1_2;
    logic [15:0] MemAddr_2;
    wire  [7:0]  MemData_2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clock = ~Clock;

    ram_arbiter #(.ADDR_W(16), .DATA_W(8), .SETUP_CYCLES(S), .STROBE_CYCLES(B)) u_dut (
        .Clock(Clock), .Reset(Reset),
        .Req0(Req0), .Write0(Write0), .Addr0(Addr0), .WData0(WData0), .Ack0(Ack0), .RData0(RData0),
        .Req1(Req1), .Write1(Write1), .Addr1(Addr1), .WData1(WData1), .Ack1(Ack1), .RData1(RData1),
        .Busy(Busy), .MemAddr(MemAddr), .MemData(MemData), .MemClk(MemClk), .MemWrite(MemWrite)
    );

    ram_arbiter #(.ADDR_W(16), .DATA_W(8), .SETUP_CYCLES(3), .STROBE_CYCLES(2)) u_dut2 (
        .Clock(Clock), .Reset(Reset),
        .Req0(Req0_2), .Write0(Write0_2), .Addr0(Addr0_2), .WData0(WData0_2), .Ack0(Ack0_2), .RData0(RData0_2),
        .Req1(Req1_2), .Write1(Write1_2), .Addr1(Addr1_2), .WData1(WData1_2), .Ack1(Ack1_2), .RData1(RData1_2),
        .Busy(Busy_2), .MemAddr(MemAddr_2), .MemData(MemData_2), .MemClk(MemClk_2), .MemWrite(MemWrite_2)
    );

    // An undriven bus reads as 8'hFF through these pullups.
    for (genvar g = 0; g < 8; g++) begin : g_pull
        pullup (MemData[g]);
        pullup (MemData_2[g]);
    end

    function automatic logic [7:0] init_pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Ram: writes on MemClk rise; a read drives the bus from MemClk rise until the Ack.
    logic [7:0] ram [logic [15:0]];
    logic       ram_oe = 1'b0;
    logic [7:0] ram_q  = '0;
    assign MemData = ram_oe ? ram_q : 8'bz;

    initial forever begin
        @(posedge MemClk);
        if (MemWrite) begin
            ram[MemAddr] = MemData;
        end else begin
            ram_q  = ram.exists(MemAddr) ? ram[MemAddr] : init_pat(MemAddr);
            ram_oe = 1'b1;
            @(posedge Ack0 or posedge Ack1 or negedge Reset);
            ram_oe = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: m_k counts busy cycles of the current access (0 = idle).
    int          m_k = 0;
    logic        m_win = 1'b0, m_wr = 1'b0, m_last = 1'b1;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wdata = '0;
    logic [7:0]  m_rdata [2];
    logic [7:0]  m_mem [logic [15:0]];

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return m_mem.exists(a) ? m_mem[a] : init_pat(a);
    endfunction

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            m_k = 0; m_last = 1'b1; m_win = 1'b0; m_wr = 1'b0;
            m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
        end else if (m_k == 0) begin
            if (Req0 || Req1) begin
`ifdef RAM_ARBITER_FIXED_PRIO_EN
                m_win = !Req0;
`else
                m_win = (Req0 && Req1) ? !m_last : Req1;
`endif
                m_last  = m_win;
                m_wr    = m_win ? Write1 : Write0;
                m_addr  = m_win ? Addr1 : Addr0;
                m_wdata = m_win ? WData1 : WData0;
                m_k     = 1;
            end
        end else if (m_k == T) begin
            m_k = 0;
        end else begin
            m_k++;
            if (m_k == T) begin
                if (m_wr) m_mem[m_addr] = m_wdata;
                else      m_rdata[m_win] = mem_rd(m_addr);
            end
        end
    end

    always @(negedge Clock) begin
        logic [7:0] exp_d;
        if (Reset) begin
            if (m_wr && m_k >= 1 && m_k < T)        exp_d = m_wdata;
            else if (!m_wr && m_k > S && m_k < T)   exp_d = mem_rd(m_addr);
            else                                    exp_d = 8'hFF;
            chk("busy",     32'(Busy),     32'(m_k != 0));
            chk("memwrite", 32'(MemWrite), 32'(m_wr && m_k >= 1 && m_k < T));
            chk("memclk",   32'(MemClk),   32'(m_k > S && m_k <= S + B));
            chk("memaddr",  32'(MemAddr),  32'(m_addr));
            chk("ack0",     32'(Ack0),     32'(m_k == T && !m_win));
            chk("ack1",     32'(Ack1),     32'(m_k == T && m_win));
            chk("rdata0",   32'(RData0),   32'(m_rdata[0]));
            chk("rdata1",   32'(RData1),   32'(m_rdata[1]));
            chk("memdata",  32'(MemData),  32'(exp_d));
        end
    end

    task automatic set_port(input int p, input logic req, input logic wr,
                            input logic [15:0] a, input logic [7:0] d);
        if (p == 0) begin
            Req0 = req; Write0 = wr; Addr0 = a; WData0 = d;
        end else begin
            Req1 = req; Write1 = wr; Addr1 = a; WData1 = d;
        end
    endtask

    // One access; lat is the cycle index (SETUP = 1) in which Ack is seen, 0 on timeout.
    task automatic access(input int p, input logic wr, input logic [15:0] a, input logic [7:0] d,
                          input int drop_at, output int lat, output int n_wr, output int n_clk,
                          output int n_d, output logic [7:0] rd);
        lat = 0; n_wr = 0; n_clk = 0; n_d = 0; rd = '0;
        @(negedge Clock);
        set_port(p, 1'b1, wr, a, d);
        for (int c = 1; c <= 30; c++) begin
            @(negedge Clock);
            if (MemWrite) n_wr++;
            if (MemClk) n_clk++;
            if (MemData == d) n_d++;
            if (c == drop_at) set_port(p, 1'b0, wr, a, d);
            if ((p == 0) ? Ack0 : Ack1) begin
                lat = c;
                rd  = (p == 0) ? RData0 : RData1;
                set_port(p, 1'b0, wr, a, d);
                break;
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n_wr, n_clk, n_d, cnt0, cnt1, busy_n, ack_n, first;
        logic [7:0] rd;
        int order[$];
        int stamp[$];
        int exp_order[8];

        // Reset state
        #2;
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_memclk", 32'(MemClk), 0);
        chk("rst_memwrite", 32'(MemWrite), 0);
        chk("rst_memaddr", 32'(MemAddr), 0);
        chk("rst_memdata_z", 32'(MemData), 32'hFF);
        chk("rst_acks", 32'({Ack0, Ack1}), 0);
        chk("rst_rdata", 32'({RData0, RData1}), 0);
        @(negedge Clock);
        Reset = 1'b1;

        // Port 0 write A5 -> 0010
        access(0, 1'b1, 16'h0010, 8'hA5, 0, lat, n_wr, n_clk, n_d, rd);
        chk("wr_latency", 32'(lat), 4);
        chk("wr_memwrite_cycles", 32'(n_wr), 3);
        chk("wr_memdata_cycles", 32'(n_d), 3);
        chk("wr_memclk_cycles", 32'(n_clk), 1);
        @(negedge Clock);
        chk("wr_memdata_released", 32'(MemData), 32'hFF);

        // Port 1 read of 0010; WData1 set to a value that would show if driven
        access(1, 1'b0, 16'h0010, 8'h66, 0, lat, n_wr, n_clk, n_d, rd);
        chk("rd_latency", 32'(lat), 4);
        chk("rd_rdata1", 32'(rd), 32'hA5);
        chk("rd_memwrite_cycles", 32'(n_wr), 0);
        chk("rd_not_driven", 32'(n_d), 0);

        // Both ports requesting, 4 accesses each
`ifdef RAM_ARBITER_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        cnt0 = 0; cnt1 = 0;
        @(negedge Clock);
        set_port(0, 1'b1, 1'b1, 16'h0100, 8'h10);
        set_port(1, 1'b1, 1'b0, 16'h0100, 8'h66);
        for (int c = 1; c <= 80 && (cnt0 < 4 || cnt1 < 4); c++) begin
            @(negedge Clock);
            if (Ack0) begin
                order.push_back(0); stamp.push_back(c); cnt0++;
                if (cnt0 == 4) Req0 = 1'b0;
                else begin Addr0 = 16'h0100 + 16'(cnt0); WData0 = 8'h10 + 8'(cnt0); end
            end
            if (Ack1) begin
                order.push_back(1); stamp.push_back(c); cnt1++;
                if (cnt1 == 4) Req1 = 1'b0;
                else Addr1 = 16'h0100 + 16'(cnt1);
            end
        end
        chk("both_ack_count", 32'(order.size()), 8);
        for (int i = 0; i < order.size() && i < 8; i++) begin
            chk($sformatf("both_order_%0d", i), 32'(order[i]), 32'(exp_order[i]));
            if (i > 0) chk($sformatf("both_spacing_%0d", i), 32'(stamp[i] - stamp[i-1]), 5);
        end

        // Reset during STROBE of a write to 0020
        @(negedge Clock);
        set_port(0, 1'b1, 1'b1, 16'h0020, 8'h5A);
        @(negedge Clock);
        @(negedge Clock);
        chk("rstmid_in_strobe", 32'(MemClk), 1);
        #1 Reset = 1'b0;
        set_port(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        #1;
        chk("rstmid_memclk", 32'(MemClk), 0);
        chk("rstmid_memwrite", 32'(MemWrite), 0);
        chk("rstmid_memdata_z", 32'(MemData), 32'hFF);
        chk("rstmid_ack", 32'({Ack0, Ack1}), 0);
        chk("rstmid_busy", 32'(Busy), 0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        chk("rstmid_idle_after", 32'(Busy), 0);
        access(1, 1'b1, 16'h0030, 8'h3C, 0, lat, n_wr, n_clk, n_d, rd);
        chk("post_rst_latency", 32'(lat), 4);

        // Port 0 read with Req dropped after one cycle
        access(0, 1'b0, 16'h0030, 8'h99, 1, lat, n_wr, n_clk, n_d, rd);
        chk("drop_latency", 32'(lat), 4);
        chk("drop_rdata0", 32'(rd), 32'h3C);
        busy_n = 0; ack_n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clock);
            if (Busy) busy_n++;
            if (Ack0) ack_n++;
        end
        chk("drop_no_second_busy", 32'(busy_n), 0);
        chk("drop_no_second_ack", 32'(ack_n), 0);

        // SETUP_CYCLES=3, STROBE_CYCLES=2 instance
        first = 0; n_clk = 0; n_wr = 0; lat = 0;
        @(negedge Clock);
        Req0_2 = 1'b1; Write0_2 = 1'b1; Addr0_2 = 16'h0040; WData0_2 = 8'h77;
        for (int c = 1; c <= 30; c++) begin
            @(negedge Clock);
            if (MemClk_2) begin
                n_clk++;
                if (first == 0) first = c;
            end
            if (MemWrite_2) n_wr++;
            if (Ack0_2) begin
                lat = c;
                Req0_2 = 1'b0;
                break;
            end
        end
        chk("p32_memclk_start", 32'(first), 4);
        chk("p32_memclk_cycles", 32'(n_clk), 2);
        chk("p32_memwrite_cycles", 32'(n_wr), 6);
        chk("p32_latency", 32'(lat), 7);

        @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
